// File: rtl/asg_challenge_ctrl_if.sv
// Challenge-controller bus: requester handshake plus the control lines toward the ASG.
// req is a level held by a requester until its ack pulse; ack is a one-cycle pulse and challenge is valid in that cycle.
interface asg_challenge_ctrl_if #(
  parameter int CH_BITS = 64
);
  logic [1:0]         req;
  logic               reseed;
  logic               asg_bit;
  logic [1:0]         ack;
  logic [CH_BITS-1:0] challenge;
  logic               busy;
  logic [1:0]         asg_load_sel;
  logic               asg_load;
  logic               asg_enable;

  modport master (
    output req, reseed, asg_bit,
    input  ack, challenge, busy, asg_load_sel, asg_load, asg_enable
  );

  modport slave (
    input  req, reseed, asg_bit,
    output ack, challenge, busy, asg_load_sel, asg_load, asg_enable
  );
endinterface

// File: rtl/asg_challenge_ctrl.sv
// Arbitrates two challenge requesters, seeds and warms the ASG when needed,
// then shifts CH_BITS ASG bits into a challenge word and acks the granted requester.
module asg_challenge_ctrl #(
  parameter int CH_BITS = 64,
  parameter int WARMUP  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  asg_challenge_ctrl_if.slave   bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WARM    = 3'd2,
    COLLECT = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int MAXN = (CH_BITS > WARMUP) ? CH_BITS : WARMUP;
  localparam int CW   = $clog2(MAXN + 1);

  state_t             state, state_next;
  logic [CW-1:0]      cnt;
  logic               seeded;
  logic               grant, grant_next;
  logic               rr_ptr;
  logic [CH_BITS-1:0] challenge_q;

  logic [1:0]         ack_c;
  logic               busy_c;
  logic [1:0]         load_sel_c;
  logic               load_c;
  logic               enable_c;

  always_comb begin
    state_next = state;
    grant_next = grant;
    ack_c      = 2'b00;
    busy_c     = (state != IDLE);
    load_sel_c = 2'b00;
    load_c     = 1'b0;
    enable_c   = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          // rr_ptr names the requester that was not granted last
          grant_next = bus.req[rr_ptr] ? rr_ptr : ~rr_ptr;
          state_next = (seeded && !bus.reseed) ? COLLECT : LOAD;
        end
      end
      LOAD: begin
        load_c     = 1'b1;
        load_sel_c = 2'(cnt);
        if (cnt == CW'(2)) state_next = (WARMUP == 0) ? COLLECT : WARM;
      end
      WARM: begin
        enable_c = 1'b1;
        if (cnt == CW'(WARMUP - 1)) state_next = COLLECT;
      end
      COLLECT: begin
        enable_c = 1'b1;
        if (cnt == CW'(CH_BITS - 1)) state_next = DONE;
      end
      DONE: begin
        ack_c      = grant ? 2'b10 : 2'b01;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      seeded      <= 1'b0;
      grant       <= 1'b0;
      rr_ptr      <= 1'b0;
      challenge_q <= '0;
    end else begin
      state <= state_next;
      grant <= grant_next;
      if (state_next != state || state == IDLE) cnt <= '0;
      else                                      cnt <= cnt + CW'(1);
      if (state == IDLE && state_next != IDLE) rr_ptr <= ~grant_next;
      // A reseed always wins, so a pulse landing on the final LOAD cycle still forces a new seed
      if (bus.reseed)                               seeded <= 1'b0;
      else if (state == LOAD && state_next != LOAD) seeded <= 1'b1;
      if (state_next == COLLECT && state != COLLECT) challenge_q <= '0;
      else if (state == COLLECT) challenge_q <= {challenge_q[CH_BITS-2:0], bus.asg_bit};
    end
  end

  assign bus.ack          = ack_c;
  assign bus.busy         = busy_c;
  assign bus.asg_load_sel = load_sel_c;
  assign bus.asg_load     = load_c;
  assign bus.asg_enable   = enable_c;
  assign bus.challenge    = challenge_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_asg_challenge_ctrl.sv
// Directed bench for asg_challenge_ctrl: seeding, latency, round-robin,
// reseed handling, mid-operation reset and req drop.
module tb_asg_challenge_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  asg_challenge_ctrl_if #(.CH_BITS(64)) bus ();

  asg_challenge_ctrl #(
    .CH_BITS (64),
    .WARMUP  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  localparam logic [63:0] ALT  = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input string tag);
    step();
    check({tag, " idle busy"}, 64'(bus.busy), 64'd0);
    check({tag, " idle ack"}, 64'(bus.ack), 64'd0);
  endtask

  // Step 1 is the edge that samples req in IDLE; ack is expected after edge 84 (unseeded) or 65 (seeded).
  // mode: 0 = asg_bit 0, 1 = asg_bit 1, 2 = alternate 1,0 starting with the first collected bit.
  task automatic run_op(input string tag, input bit exp_load, input int mode,
                        input logic [1:0] exp_ack, input logic [63:0] exp_ch,
                        input int drop_at, input int reseed_at);
    int lat;
    int first;
    bit got;
    lat   = exp_load ? 84 : 65;
    first = exp_load ? 21 : 2;
    got   = 1'b0;
    for (int s = 1; s <= lat + 4 && !got; s++) begin
      bus.asg_bit = (mode == 2) ? (s >= first && ((s - first) % 2 == 0)) : (mode == 1);
      bus.reseed  = (s == reseed_at);
      step();
      bus.reseed = 1'b0;
      if (s == drop_at) bus.req = 2'b00;
      if (s == 1) check({tag, " busy"}, 64'(bus.busy), 64'd1);
      if (exp_load && s <= 3) begin
        check({tag, " load"}, 64'(bus.asg_load), 64'd1);
        check({tag, " load_sel"}, 64'(bus.asg_load_sel), 64'(s - 1));
        check({tag, " load enable"}, 64'(bus.asg_enable), 64'd0);
      end
      if ((exp_load && s == 4) || (!exp_load && s == 1)) begin
        check({tag, " run load"}, 64'(bus.asg_load), 64'd0);
        check({tag, " run enable"}, 64'(bus.asg_enable), 64'd1);
      end
      if (bus.ack != 2'b00) begin
        got = 1'b1;
        check({tag, " latency"}, 64'(s), 64'(lat));
        check({tag, " ack"}, 64'(bus.ack), 64'(exp_ack));
        check({tag, " challenge"}, bus.challenge, exp_ch);
        check({tag, " done enable"}, 64'(bus.asg_enable), 64'd0);
      end
    end
    if (!got) check({tag, " ack timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    reset       = 1'b0;
    bus.req     = 2'b00;
    bus.reseed  = 1'b0;
    bus.asg_bit = 1'b0;

    step();
    step();
    check("rst state", 64'(dbg_state), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst ack", 64'(bus.ack), 64'd0);
    check("rst challenge", bus.challenge, 64'd0);
    check("rst load", 64'(bus.asg_load), 64'd0);
    check("rst load_sel", 64'(bus.asg_load_sel), 64'd0);
    check("rst enable", 64'(bus.asg_enable), 64'd0);
    reset = 1'b1;
    idle_step("post rst");

    // First request after reset must seed and warm up
    bus.req = 2'b01;
    run_op("s1", 1'b1, 2, 2'b01, ALT, 0, 0);
    bus.req = 2'b00;
    idle_step("s1");
    check("s1 challenge hold", bus.challenge, ALT);

    bus.req = 2'b01;
    run_op("s2", 1'b0, 1, 2'b01, ONES, 0, 0);
    bus.req = 2'b00;
    idle_step("s2");

    bus.req = 2'b10;
    run_op("r1", 1'b0, 0, 2'b10, 64'd0, 0, 0);
    bus.req = 2'b00;
    idle_step("r1");

    // Both requesters held: grants alternate, one IDLE cycle between them
    bus.req = 2'b11;
    run_op("s3a", 1'b0, 1, 2'b01, ONES, 0, 0);
    idle_step("s3a");
    run_op("s3b", 1'b0, 2, 2'b10, ALT, 0, 0);
    idle_step("s3b");
    run_op("s3c", 1'b0, 0, 2'b01, 64'd0, 0, 0);
    bus.req = 2'b00;
    idle_step("s3c");
    idle_step("s3 quiet");

    // Reseed during COLLECT leaves this op alone but forces LOAD next time
    bus.req = 2'b01;
    run_op("s4a", 1'b0, 1, 2'b01, ONES, 0, 20);
    bus.req = 2'b00;
    idle_step("s4a");
    bus.req = 2'b10;
    run_op("s4b", 1'b1, 0, 2'b10, 64'd0, 0, 0);
    bus.req = 2'b00;
    idle_step("s4b");

    // Reset asserted mid-COLLECT
    bus.req     = 2'b01;
    bus.asg_bit = 1'b1;
    for (int s = 1; s <= 31; s++) step();
    check("s5 pre busy", 64'(bus.busy), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("s5 state", 64'(dbg_state), 64'd0);
    check("s5 busy", 64'(bus.busy), 64'd0);
    check("s5 enable", 64'(bus.asg_enable), 64'd0);
    check("s5 load", 64'(bus.asg_load), 64'd0);
    check("s5 load_sel", 64'(bus.asg_load_sel), 64'd0);
    check("s5 challenge", bus.challenge, 64'd0);
    check("s5 ack", 64'(bus.ack), 64'd0);
    for (int i = 0; i < 3; i++) idle_step("s5 held");
    reset = 1'b1;
    run_op("s5 reseed", 1'b1, 2, 2'b01, ALT, 0, 0);
    bus.req = 2'b00;
    idle_step("s5");

    // reseed and req together in IDLE while seeded
    bus.req = 2'b10;
    run_op("same cycle", 1'b1, 0, 2'b10, 64'd0, 0, 1);
    bus.req = 2'b00;
    idle_step("same cycle");

    // req dropped 5 cycles after the grant
    bus.req = 2'b01;
    run_op("s6", 1'b0, 2, 2'b01, ALT, 6, 0);
    for (int i = 0; i < 4; i++) idle_step("s6");
    check("s6 challenge hold", bus.challenge, ALT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
